// File: rtl/inst_buffer_pkg.sv
// Shared dispatch-stage types for the instruction buffer: the decoded
// packet handed to the reservation station and the default buffer depth.
package inst_buffer_pkg;

  localparam int IB_SIZE = 8;

  typedef struct packed {
    logic        valid;
    logic [31:0] PC;
    logic [31:0] inst;
    logic [4:0]  dest_reg_idx;
  } DP_RS_PACKET;

endpackage

// File: rtl/inst_buffer_if.sv
// Fetch/decode-to-dispatch channel: enqueue side (if_valid/if_packet, backpressured
// by full) and dequeue side (dp_rs_packet/ib_valid, consumed by read_enable).
interface inst_buffer_if
  import inst_buffer_pkg::*;
#(
  parameter int IB_DEPTH = IB_SIZE
);

  // Handshake: a packet moves in when if_valid is high and full is low at the
  // rising edge; the head moves out when ib_valid and read_enable are both high.
  logic                      if_valid;
  DP_RS_PACKET               if_packet;
  logic                      full;
  logic                      read_enable;
  DP_RS_PACKET               dp_rs_packet;
  logic                      ib_valid;
  logic [$clog2(IB_DEPTH):0] count;

  modport master (
    output if_valid, if_packet, read_enable,
    input  full, dp_rs_packet, ib_valid, count
  );

  modport slave (
    input  if_valid, if_packet, read_enable,
    output full, dp_rs_packet, ib_valid, count
  );

endinterface

// File: rtl/inst_buffer.sv
// Circular instruction buffer between decode and the reservation station.
// Full/empty come only from the registered count; flush squashes everything.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int IB_DEPTH = IB_SIZE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  inst_buffer_if.slave ib
);

  localparam int PW = $clog2(IB_DEPTH);
  localparam int CW = PW + 1;

  DP_RS_PACKET     entries [IB_DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count_q;
  logic            enq;
  logic            deq;
  logic            empty;

  assign empty    = (count_q == '0);
  assign ib.full  = (count_q == CW'(IB_DEPTH));
  assign ib.ib_valid = !empty;
  assign ib.count = count_q;

  // No same-cycle dequeue credit: a full buffer refuses enqueue outright.
  assign enq = ib.if_valid && !ib.full && !flush;
  assign deq = ib.read_enable && !empty && !flush;

  always_comb begin
    ib.dp_rs_packet = '0;
    if (!empty) begin
      ib.dp_rs_packet = entries[head];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      for (int i = 0; i < IB_DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      for (int i = 0; i < IB_DEPTH; i++) begin
        entries[i].valid <= 1'b0;
      end
    end else begin
      if (enq) begin
        entries[tail]       <= ib.if_packet;
        entries[tail].valid <= 1'b1;
        tail                <= tail + PW'(1);
      end
      if (deq) begin
        entries[head].valid <= 1'b0;
        head                <= head + PW'(1);
      end
      case ({enq, deq})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: fill, drain, steady-state traffic with
// pointer wrap, flush priority, empty latency and asynchronous reset.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int DEPTH = 8;

  logic clock;
  logic reset;
  logic flush;

  int tests_run;
  int tests_failed;

  logic [31:0] exp_q[$];

  inst_buffer_if #(.IB_DEPTH(DEPTH)) ib_if ();

  inst_buffer #(.IB_DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .ib    (ib_if)
  );

  // Clock/reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic DP_RS_PACKET mk_pkt(input logic [31:0] pc);
    DP_RS_PACKET p;
    p.valid        = 1'b1;
    p.PC           = pc;
    p.inst         = ~pc;
    p.dest_reg_idx = pc[6:2];
    return p;
  endfunction

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rd);
    ib_if.if_valid    = v;
    ib_if.if_packet   = v ? mk_pkt(pc) : '0;
    ib_if.read_enable = rd;
  endtask

  task automatic check_head(input string tag);
    check({tag, "_valid"}, 72'(ib_if.ib_valid), 72'(1));
    check({tag, "_pkt"}, 72'(ib_if.dp_rs_packet), 72'(mk_pkt(exp_q[0])));
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_count"}, 72'(ib_if.count), 72'(0));
    check({tag, "_ib_valid"}, 72'(ib_if.ib_valid), 72'(0));
    check({tag, "_full"}, 72'(ib_if.full), 72'(0));
    check({tag, "_pkt_zero"}, 72'(ib_if.dp_rs_packet), 72'(0));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    flush        = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    reset = 1'b1;
    repeat (2) step();
    check_empty("reset");
    reset = 1'b0;
    step();

    // Fill: eight enqueues, then a ninth that must be dropped
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0);
      exp_q.push_back(32'(i * 4));
      step();
      check($sformatf("fill_count%0d", i), 72'(ib_if.count), 72'(i + 1));
    end
    check("fill_full", 72'(ib_if.full), 72'(1));
    drive(1'b1, 32'h20, 1'b0);
    step();
    check("fill_drop_count", 72'(ib_if.count), 72'(8));
    check_head("fill_drop_head");

    // Drain: read_enable held nine cycles
    drive(1'b0, 32'h0, 1'b1);
    for (int c = 0; c < DEPTH + 1; c++) begin
      if (exp_q.size() > 0) begin
        check_head($sformatf("drain%0d", c));
        void'(exp_q.pop_front());
      end else begin
        check($sformatf("drain%0d_empty", c), 72'(ib_if.ib_valid), 72'(0));
      end
      step();
    end
    drive(1'b0, 32'h0, 1'b0);
    check_empty("drain_end");

    // Steady traffic at count 3; 23 total enqueues wrap the tail twice
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h100 + 32'(i * 4), 1'b0);
      exp_q.push_back(32'h100 + 32'(i * 4));
      step();
    end
    for (int c = 0; c < 20; c++) begin
      logic [31:0] pc;
      pc = 32'h200 + 32'(c * 4);
      check_head($sformatf("traffic%0d", c));
      drive(1'b1, pc, 1'b1);
      exp_q.push_back(pc);
      step();
      void'(exp_q.pop_front());
      check($sformatf("traffic%0d_count", c), 72'(ib_if.count), 72'(3));
    end
    drive(1'b0, 32'h0, 1'b0);
    check_head("traffic_after");

    // Flush priority at count 5
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h300 + 32'(i * 4), 1'b0);
      exp_q.push_back(32'h300 + 32'(i * 4));
      step();
    end
    check("flush_pre_count", 72'(ib_if.count), 72'(5));
    flush = 1'b1;
    drive(1'b1, 32'hDEAD0, 1'b1);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    exp_q.delete();
    check_empty("flush");
    step();
    check_empty("flush_hold");

    // Empty latency and underflow
    drive(1'b1, 32'h40, 1'b1);
    check("lat_same_cycle_valid", 72'(ib_if.ib_valid), 72'(0));
    exp_q.push_back(32'h40);
    step();
    drive(1'b0, 32'h0, 1'b0);
    check("lat_count", 72'(ib_if.count), 72'(1));
    check_head("lat_next");

    // Asynchronous reset mid-cycle at count 6
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h500 + 32'(i * 4), 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 1'b0);
    check("areset_pre_count", 72'(ib_if.count), 72'(6));
    #3;
    reset = 1'b1;
    #1;
    check_empty("areset_async");
    step();
    reset = 1'b0;
    exp_q.delete();
    step();
    check_empty("areset_release");
    drive(1'b1, 32'h80, 1'b0);
    exp_q.push_back(32'h80);
    step();
    drive(1'b0, 32'h0, 1'b1);
    check("areset_new_count", 72'(ib_if.count), 72'(1));
    check_head("areset_new");
    step();
    drive(1'b0, 32'h0, 1'b0);
    check_empty("areset_final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/inst_buffer.md
INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 SHALL have parameter IB_DEPTH, default 8, meaning number of entries; legal values are powers of two, 4 or more.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port flush, input, 1 bit: branch-mispredict squash (take_branch).
REQ-005 SHALL have port if_valid, input, 1 bit: the fetch/decode packet is offered this cycle.
REQ-006 SHALL have port if_packet, input, type DP_RS_PACKET: decoded instruction to enqueue.
REQ-007 SHALL have port read_enable, input, 1 bit: the reservation station has a free ALU slot and a free MEM slot and consumes the head packet.
REQ-008 SHALL have port dp_rs_packet, output, type DP_RS_PACKET: head entry; .valid = ib_valid.
REQ-009 SHALL have port ib_valid, output, 1 bit: the buffer is non-empty.
REQ-010 SHALL have port full, output, 1 bit: count == IB_DEPTH; fetch stalls on it.
REQ-011 SHALL have port count, output, $clog2(IB_DEPTH)+1 bits: the number of occupied entries.

Function
REQ-012 SHALL accept an enqueue iff if_valid && !full && !flush; enqueue writes if_packet at tail, advances tail.
REQ-013 SHALL perform a dequeue iff read_enable && ib_valid && !flush; dequeue advances head.
REQ-014 SHALL ignore read_enable when the buffer is empty: no pointer change, no underflow.
REQ-015 SHALL drop if_valid while full; the packet is not written and the upstream stage holds it.
REQ-016 SHALL take full from registered count only, with no same-cycle dequeue credit, so enqueue is refused when full even if a dequeue occurs in the same cycle.
REQ-017 SHALL, for simultaneous enqueue and dequeue with 0 < count < IB_DEPTH, leave count unchanged and move both pointers.
REQ-018 SHALL provide no bypass: an entry written into an empty buffer appears at dp_rs_packet on the next cycle (1-cycle latency).
REQ-019 SHALL drive dp_rs_packet combinationally from the head entry; when empty, dp_rs_packet SHALL be all zero.
REQ-020 SHALL wrap head and tail pointers modulo IB_DEPTH; count SHALL be the sole full/empty indicator.
REQ-021 SHALL, on flush, in the next cycle set head = tail = 0, count = 0 and clear all entry valid bits; flush has priority over same-cycle enqueue and dequeue.
REQ-022 SHALL never lose or reorder accepted packets: dequeue order = enqueue order.

Reset
REQ-023 SHALL, while reset is high, asynchronously force head = 0, tail = 0, count = 0, all entries = 0, ib_valid = 0, full = 0 and dp_rs_packet = 0.
REQ-024 SHALL, after reset is released mid-operation, behave as empty; no stale entry becomes visible.

Structure
REQ-025 SHALL use DP_RS_PACKET and the IB_DEPTH default (`IB_SIZE) from the shared sys_defs package; no new typedefs are local to the module.
REQ-026 SHALL be a single module with no sub-module; the storage is an array of DP_RS_PACKET plus head/tail/count registers.

Verification
REQ-027 SHALL cover fill: 8 consecutive enqueues with PC 0x00..0x1C and no reads -> full = 1, count = 8; a 9th if_valid with PC 0x20 is dropped.
REQ-028 SHALL cover drain: after the fill, read_enable held for 9 cycles -> PCs 0x00..0x1C appear in order, then ib_valid = 0 and count stays 0.
REQ-029 SHALL cover simultaneous traffic: at count = 3, enqueue and read together for 20 cycles -> count stays 3, order is preserved, and the pointers wrap correctly twice.
REQ-030 SHALL cover flush priority: at count = 5, flush, if_valid and read_enable together -> next cycle count = 0, ib_valid = 0, and the enqueued packet is absent.
REQ-031 SHALL cover empty latency and underflow: on an empty buffer, enqueue PC 0x40 with read_enable high -> the same cycle shows ib_valid = 0 with no dequeue; the next cycle shows dp_rs_packet.PC = 0x40.
REQ-032 SHALL cover async reset: assert reset mid-cycle at count = 6 -> outputs go to zero before the next edge; after release, ib_valid = 0 and the first new enqueue appears alone at the head.
